instr_loader: RTL



---
 rtl/instr_loader_if.sv | 39 +++
 rtl/instr_loader.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/instr_loader_if.sv
// instr_loader_if: handshake and memory-write bundle for instr_loader.
//   master : program source side (drives start/len/in_valid/in_data,
//            observes everything else)
//   slave  : loader side (instr_loader)
// Signals:
//   start, len          load request and word count (D+1 bits)
//   in_valid, in_data   incoming machine-code word stream
//   in_ready            loader accepts in_data this cycle
//   wr_en/addr/data     instruction-memory write port
//   busy, done          load status
//   cpu_hold            core held in reset / PC frozen
//   err                 checksum mismatch (checksum builds only)
interface instr_loader_if #(
    parameter int unsigned D = 10,
    parameter int unsigned W = 9
);
    logic         start;
    logic [D:0]   len;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         wr_en;
    logic [D-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         busy;
    logic         done;
    logic         cpu_hold;
    logic         err;

    modport master (
        output start, len, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, cpu_hold, err
    );

    modport slave (
        input  start, len, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, cpu_hold, err
    );
endinterface

// File: rtl/instr_loader.sv
// instr_loader: accepts a stream of W-bit machine-code words over a
// valid/ready handshake and writes them to instruction memory at
// sequential addresses starting at 0. Holds the core (cpu_hold) until a
// load completes.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    instr_loader_if.slave (start/len, in_valid/in_data/in_ready,
//          wr_en/wr_addr/wr_data, busy, done, cpu_hold, err)
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN
//   When defined, one extra checksum word (XOR of all loaded words) is
//   accepted after the last data word; a mismatch raises err and keeps
//   the core held. When undefined, err is tied 0.
module instr_loader #(
    parameter int unsigned D = 10,
    parameter int unsigned W = 9
) (
    input logic          clk,
    input logic          reset,
    instr_loader_if.slave bus
);

`ifdef INSTR_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, CHK, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

    localparam logic [D:0] LEN_MAX = {1'b1, {D{1'b0}}};
    localparam logic [D:0] CNT_ONE = {{D{1'b0}}, 1'b1};

    state_t       state;
    logic [D:0]   len_q;
    logic [D:0]   cnt;
    logic         in_ready_q;
    logic         wr_en_q;
    logic [D-1:0] wr_addr_q;
    logic [W-1:0] wr_data_q;
    logic         busy_q;
    logic         done_q;
    logic         cpu_hold_q;

    logic         start_ok;
    logic         accept;
    logic [D:0]   cnt_inc;
    logic         last_word;
    logic [D:0]   len_sat;

    assign start_ok  = bus.start && (bus.len != '0);
    assign accept    = bus.in_valid && in_ready_q;
    assign cnt_inc   = cnt + CNT_ONE;
    assign last_word = (cnt_inc == len_q);
    assign len_sat   = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic         err_q;
    logic [W-1:0] csum;
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.cpu_hold = cpu_hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= '0;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cpu_hold_q <= 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            err_q      <= 1'b0;
            csum       <= '0;
`endif
        end else begin
            // Write strobe only in the cycle right after a data accept.
            wr_en_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state      <= LOAD;
                        len_q      <= len_sat;
                        cnt        <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        cpu_hold_q <= 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        err_q      <= 1'b0;
                        csum       <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (!in_ready_q) begin
                        // in_ready already dropped after the final accept;
                        // the final write strobe is out this cycle.
                        state      <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                    end else if (accept) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cnt[D-1:0];
                        wr_data_q <= bus.in_data;
                        cnt       <= cnt_inc;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        csum      <= csum ^ bus.in_data;
                        if (last_word) begin
                            state <= CHK;
                        end
`else
                        if (last_word) begin
                            in_ready_q <= 1'b0;
                        end
`endif
                    end
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                CHK: begin
                    // Checksum word is consumed but never written.
                    if (accept) begin
                        state      <= DONE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (bus.in_data == csum) begin
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
